// File: rtl/regbank_pkg.sv
// regbank_pkg: shared sizes, sequencer states and command opcodes for regbank_seq
package regbank_pkg;
   localparam int NREGS_D = 32;
   localparam int AW_D = 5;
   localparam int DW_D = 32;
   typedef enum logic [2:0] {S_IDLE, S_FILL, S_RD, S_OUT0, S_OUT1} state_t;
   typedef enum logic {OP_FILL = 1'b0, OP_DUMP = 1'b1} op_t;
endpackage

// File: rtl/regbank_seq_if.sv
// regbank_seq_if: command, bank-port, dump-stream and status signals of regbank_seq
interface regbank_seq_if
   import regbank_pkg::*;
#(
   parameter int AW = AW_D,
   parameter int DW = DW_D
);
   logic cmd_valid;
   logic cmd_ready;
   logic cmd_op;
   logic [DW-1:0] cmd_base;
   logic [DW-1:0] cmd_step;
   logic rb_write;
   logic [AW-1:0] rb_dr;
   logic [DW-1:0] rb_wrData;
   logic [AW-1:0] rb_sr1;
   logic [AW-1:0] rb_sr2;
   logic [DW-1:0] rb_rdData1;
   logic [DW-1:0] rb_rdData2;
   logic out_valid;
   logic out_ready;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_addr;
   logic out_last;
   logic busy;
   logic chk_err;
   logic [5:0] chk_cnt;
   modport master (
      input cmd_valid, cmd_op, cmd_base, cmd_step, rb_rdData1, rb_rdData2, out_ready,
      output cmd_ready, rb_write, rb_dr, rb_wrData, rb_sr1, rb_sr2,
      output out_valid, out_data, out_addr, out_last, busy, chk_err, chk_cnt
   );
   modport slave (
      output cmd_valid, cmd_op, cmd_base, cmd_step, rb_rdData1, rb_rdData2, out_ready,
      input cmd_ready, rb_write, rb_dr, rb_wrData, rb_sr1, rb_sr2,
      input out_valid, out_data, out_addr, out_last, busy, chk_err, chk_cnt
   );
endinterface

// File: rtl/regbank_seq_chk.sv
// regbank_seq_chk: expected-value generator and comparator for dump beats after a FILL
module regbank_seq_chk
   import regbank_pkg::*;
#(
   parameter int AW = AW_D,
   parameter int DW = DW_D
) (
   input logic clk,
   input logic reset,
   input logic fill_go,
   input logic [DW-1:0] base,
   input logic [DW-1:0] step,
   input logic beat,
   input logic [AW-1:0] addr,
   input logic [DW-1:0] data,
   output logic err,
   output logic [5:0] cnt
);
   logic [DW-1:0] base_q, step_q, expv;
   logic armed, miss;
   assign expv = base_q + DW'(addr) * step_q;
   assign miss = armed && beat && data != expv;
   // retain the last FILL pattern and accumulate mismatches seen on handshaken beats
   always_ff @(posedge clk) begin
      if (!reset) begin
         base_q <= '0;
         step_q <= '0;
         armed <= 1'b0;
         err <= 1'b0;
         cnt <= '0;
      end else if (fill_go) begin
         base_q <= base;
         step_q <= step;
         armed <= 1'b1;
         err <= 1'b0;
         cnt <= '0;
      end else if (miss) begin
         err <= 1'b1;
         cnt <= cnt == 6'd63 ? cnt : cnt + 6'd1;
      end
   end
endmodule

// File: rtl/regbank_seq.sv
// regbank_seq: FILL/DUMP initiator for the register bank; dump checker built with REGBANK_SEQ_CHECK_EN
module regbank_seq
   import regbank_pkg::*;
#(
   parameter int NREGS = NREGS_D,
   parameter int AW = AW_D,
   parameter int DW = DW_D
) (
   input logic clk,
   input logic reset,
   regbank_seq_if.master bus
);
   state_t state, nxt;
   logic [AW-1:0] idx, pair, sr1_q, sr2_q;
   logic [DW-1:0] acc, step_q, buf0, buf1;
   logic live, accept, fire, last_pair;
   assign accept = bus.cmd_valid && bus.cmd_ready;
   assign fire = bus.out_valid && bus.out_ready;
   assign pair = idx << 1;
   assign last_pair = idx == AW'(NREGS / 2 - 1);
   assign bus.cmd_ready = live && state == S_IDLE;
   assign bus.busy = state != S_IDLE;
   assign bus.rb_write = state == S_FILL;
   assign bus.rb_dr = idx;
   assign bus.rb_wrData = acc;
   assign bus.rb_sr1 = state == S_RD ? pair : sr1_q;
   assign bus.rb_sr2 = state == S_RD ? pair | AW'(1) : sr2_q;
   assign bus.out_valid = state == S_OUT0 || state == S_OUT1;
   assign bus.out_data = state == S_OUT1 ? buf1 : buf0;
   assign bus.out_addr = state == S_OUT1 ? pair | AW'(1) : pair;
   assign bus.out_last = state == S_OUT1 && last_pair;
   // state register
   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else state <= nxt;
   end
   // next-state: fill walks every index, dump cycles RD -> OUT0 -> OUT1 per pair
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE: nxt = accept ? (op_t'(bus.cmd_op) == OP_DUMP ? S_RD : S_FILL) : S_IDLE;
         S_FILL: nxt = idx == AW'(NREGS - 1) ? S_IDLE : S_FILL;
         S_RD: nxt = S_OUT0;
         S_OUT0: nxt = bus.out_ready ? S_OUT1 : S_OUT0;
         S_OUT1: nxt = bus.out_ready ? (last_pair ? S_IDLE : S_RD) : S_OUT1;
         default: nxt = S_IDLE;
      endcase
   end
   // datapath: index/accumulator for fill, pair buffer and held read addresses for dump
   always_ff @(posedge clk) begin
      if (!reset) begin
         live <= 1'b0;
         idx <= '0;
         acc <= '0;
         step_q <= '0;
         buf0 <= '0;
         buf1 <= '0;
         sr1_q <= '0;
         sr2_q <= '0;
      end else begin
         live <= 1'b1;
         if (accept) begin
            idx <= '0;
            acc <= bus.cmd_base;
            step_q <= bus.cmd_step;
         end
         if (state == S_FILL) begin
            idx <= idx + AW'(1);
            acc <= acc + step_q;
         end
         if (state == S_RD) begin
            buf0 <= bus.rb_rdData1;
            buf1 <= bus.rb_rdData2;
            sr1_q <= pair;
            sr2_q <= pair | AW'(1);
         end
         if (state == S_OUT1 && bus.out_ready) idx <= idx + AW'(1);
      end
   end
`ifdef REGBANK_SEQ_CHECK_EN
   regbank_seq_chk #(.AW(AW), .DW(DW)) u_chk (
      .clk(clk),
      .reset(reset),
      .fill_go(accept && op_t'(bus.cmd_op) == OP_FILL),
      .base(bus.cmd_base),
      .step(bus.cmd_step),
      .beat(fire),
      .addr(bus.out_addr),
      .data(bus.out_data),
      .err(bus.chk_err),
      .cnt(bus.chk_cnt)
   );
`else
   assign bus.chk_err = 1'b0;
   assign bus.chk_cnt = '0;
   logic unused_fire;
   assign unused_fire = fire;
`endif
endmodule

// File: tb/tb_regbank_seq.sv
// tb_regbank_seq: randomized FILL/DUMP bench with a bank model and an arithmetic reference
module tb_regbank_seq;
   typedef struct {
      logic [4:0] a;
      logic [31:0] d;
      logic l;
   } beat_t;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [31:0] bank [32];
   logic [31:0] ref_regs [32];
   logic frc = 1'b0;
   logic [4:0] frc_a = '0;
   logic [31:0] frc_d = '0;
   regbank_seq_if bus ();
   regbank_seq dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   assign bus.rb_rdData1 = bank[bus.rb_sr1];
   assign bus.rb_rdData2 = bank[bus.rb_sr2];
   // bank model: one write port, bench override port for corrupting a register
   always @(posedge clk) begin
      if (frc) bank[frc_a] <= frc_d;
      else if (bus.rb_write) bank[bus.rb_dr] <= bus.rb_wrData;
   end
   // watchdog
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask
   task automatic issue(input logic op, input logic [31:0] b, input logic [31:0] s);
      int w = 0;
      while (bus.cmd_ready !== 1'b1 && w < 200) begin
         step_clk();
         w++;
      end
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL issue_wait: cmd_ready=%b required 1", bus.cmd_ready);
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_op = op;
      bus.cmd_base = b;
      bus.cmd_step = s;
      step_clk();
      bus.cmd_valid = 1'b0;
      bus.cmd_base = $urandom;
      bus.cmd_step = $urandom;
   endtask
   task automatic do_fill(input logic [31:0] b, input logic [31:0] s);
      issue(1'b0, b, s);
      for (int i = 0; i < 32; i++) begin
         ref_regs[i] = b + 32'(i) * s;
         checks++;
         if (bus.rb_write !== 1'b1 || bus.rb_dr !== 5'(i) || bus.rb_wrData !== ref_regs[i] || bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_beat%0d: write=%b dr=%0d data=%h ready=%b required 1 %0d %h 0", i, bus.rb_write, bus.rb_dr, bus.rb_wrData, bus.cmd_ready, i, ref_regs[i]);
         end
         step_clk();
      end
      checks++;
      if (bus.rb_write !== 1'b0 || bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL fill_end: write=%b ready=%b required 0 1", bus.rb_write, bus.cmd_ready);
      end
   endtask
   task automatic do_dump(input int mode, input int exp_cyc, input bit do_issue);
      beat_t q[$];
      beat_t prev;
      logic pv = 1'b0;
      logic pr = 1'b0;
      int c = 1;
      if (do_issue) issue(1'b1, $urandom, $urandom);
      while (c < 400 && bus.cmd_ready !== 1'b1) begin
         bus.out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'((c / 2) % 2 == 0) : 1'($urandom_range(0, 1));
         if (pv && !pr) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_addr !== prev.a || bus.out_data !== prev.d || bus.out_last !== prev.l) begin
               errors++;
               $display("FAIL stall_hold: valid=%b addr=%0d data=%h last=%b required 1 %0d %h %b", bus.out_valid, bus.out_addr, bus.out_data, bus.out_last, prev.a, prev.d, prev.l);
            end
         end
         pv = bus.out_valid;
         pr = bus.out_ready;
         prev = '{bus.out_addr, bus.out_data, bus.out_last};
         if (bus.out_valid === 1'b1 && bus.out_ready) q.push_back(prev);
         step_clk();
         c++;
      end
      bus.out_ready = 1'b0;
      checks++;
      if (c >= 400) begin
         errors++;
         $display("FAIL dump_timeout: cycles=%0d required <400", c);
      end
      if (exp_cyc > 0) begin
         checks++;
         if (c != exp_cyc) begin
            errors++;
            $display("FAIL dump_cycles: idle after %0d cycles required %0d", c, exp_cyc);
         end
      end
      checks++;
      if (q.size() != 32) begin
         errors++;
         $display("FAIL dump_count: beats=%0d required 32", q.size());
      end
      for (int j = 0; j < q.size() && j < 32; j++) begin
         checks++;
         if (q[j].a !== 5'(j) || q[j].d !== ref_regs[j] || q[j].l !== (j == 31)) begin
            errors++;
            $display("FAIL dump_beat%0d: addr=%0d data=%h last=%b required %0d %h %b", j, q[j].a, q[j].d, q[j].l, j, ref_regs[j], j == 31);
         end
      end
   endtask
   task automatic test_reset();
      reset = 1'b0;
      repeat (3) step_clk();
      checks++;
      if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b0 || bus.rb_write !== 1'b0 || bus.rb_dr !== '0 || bus.rb_wrData !== '0 || bus.rb_sr1 !== '0 || bus.rb_sr2 !== '0 || bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_addr !== '0 || bus.out_last !== 1'b0 || bus.chk_err !== 1'b0 || bus.chk_cnt !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ready=%b busy=%b wr=%b dr=%0d wd=%h sr=%0d/%0d ov=%b od=%h oa=%0d ol=%b ce=%b cc=%0d required all 0", bus.cmd_ready, bus.busy, bus.rb_write, bus.rb_dr, bus.rb_wrData, bus.rb_sr1, bus.rb_sr2, bus.out_valid, bus.out_data, bus.out_addr, bus.out_last, bus.chk_err, bus.chk_cnt);
      end
      reset = 1'b1;
      step_clk();
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: cmd_ready=%b required 1", bus.cmd_ready);
      end
   endtask
   task automatic test_fill();
      do_fill(32'd0, 32'd10);
      checks++;
      if (bank[31] !== 32'd310) begin
         errors++;
         $display("FAIL fill_reg31: got %0d required 310", bank[31]);
      end
   endtask
   task automatic test_dump_full();
      do_dump(0, 49, 1'b1);
      checks++;
      if (bus.chk_err !== 1'b0 || bus.chk_cnt !== 6'd0) begin
         errors++;
         $display("FAIL dump_clean_chk: err=%b cnt=%0d required 0 0", bus.chk_err, bus.chk_cnt);
      end
   endtask
   task automatic test_dump_backpressure();
      do_dump(1, 0, 1'b1);
      do_fill($urandom, $urandom);
      do_dump(2, 0, 1'b1);
   endtask
   task automatic test_wrap();
      do_fill(32'hFFFF_FFF0, 32'd1);
      checks++;
      if (bank[16] !== 32'h0 || bank[31] !== 32'hF) begin
         errors++;
         $display("FAIL wrap: reg16=%h reg31=%h required 00000000 0000000f", bank[16], bank[31]);
      end
      do_dump(2, 0, 1'b1);
   endtask
   task automatic test_back_to_back();
      logic [31:0] b = $urandom;
      logic [31:0] s = $urandom;
      issue(1'b0, b, s);
      bus.cmd_valid = 1'b1;
      bus.cmd_op = 1'b1;
      for (int i = 0; i < 32; i++) begin
         ref_regs[i] = b + 32'(i) * s;
         checks++;
         if (bus.rb_write !== 1'b1 || bus.rb_dr !== 5'(i) || bus.rb_wrData !== ref_regs[i]) begin
            errors++;
            $display("FAIL b2b_fill%0d: write=%b dr=%0d data=%h required 1 %0d %h", i, bus.rb_write, bus.rb_dr, bus.rb_wrData, i, ref_regs[i]);
         end
         step_clk();
      end
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_idle: cmd_ready=%b required 1", bus.cmd_ready);
      end
      step_clk();
      bus.cmd_valid = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.rb_sr1 !== 5'd0 || bus.rb_sr2 !== 5'd1) begin
         errors++;
         $display("FAIL b2b_start: busy=%b sr1=%0d sr2=%0d required 1 0 1", bus.busy, bus.rb_sr1, bus.rb_sr2);
      end
      do_dump(2, 0, 1'b0);
   endtask
   task automatic test_reset_mid_fill();
      logic [31:0] b = $urandom;
      logic [31:0] s = $urandom;
      issue(1'b0, b, s);
      for (int i = 0; i < 12; i++) begin
         ref_regs[i] = b + 32'(i) * s;
         if (i == 11) reset = 1'b0;
         step_clk();
      end
      checks++;
      if (bus.rb_write !== 1'b0 || bus.cmd_ready !== 1'b0 || bus.busy !== 1'b0 || bus.rb_dr !== '0 || bus.rb_wrData !== '0) begin
         errors++;
         $display("FAIL midfill_reset: write=%b ready=%b busy=%b dr=%0d wd=%h required 0 0 0 0 0", bus.rb_write, bus.cmd_ready, bus.busy, bus.rb_dr, bus.rb_wrData);
      end
      step_clk();
      reset = 1'b1;
      step_clk();
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL midfill_release: cmd_ready=%b required 1", bus.cmd_ready);
      end
      for (int j = 0; j < 32; j++) begin
         checks++;
         if (bank[j] !== ref_regs[j]) begin
            errors++;
            $display("FAIL midfill_reg%0d: got %h required %h", j, bank[j], ref_regs[j]);
         end
      end
      do_dump(2, 0, 1'b1);
   endtask
   task automatic test_checker();
      do_fill(32'd0, 32'd10);
      frc = 1'b1;
      frc_a = 5'd5;
      frc_d = 32'd7;
      step_clk();
      frc = 1'b0;
      ref_regs[5] = 32'd7;
      do_dump(0, 49, 1'b1);
      checks++;
`ifdef REGBANK_SEQ_CHECK_EN
      if (bus.chk_err !== 1'b1 || bus.chk_cnt !== 6'd1) begin
         errors++;
         $display("FAIL checker: err=%b cnt=%0d required 1 1", bus.chk_err, bus.chk_cnt);
      end
`else
      if (bus.chk_err !== 1'b0 || bus.chk_cnt !== 6'd0) begin
         errors++;
         $display("FAIL checker: err=%b cnt=%0d required 0 0", bus.chk_err, bus.chk_cnt);
      end
`endif
   endtask
   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op = 1'b0;
      bus.cmd_base = '0;
      bus.cmd_step = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_fill();
      test_dump_full();
      test_dump_backpressure();
      test_wrap();
      test_back_to_back();
      test_wrap();
      test_reset_mid_fill();
      test_checker();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
